// File: rtl/crossbar_arb.sv
// N_IN x N_OUT crossbar with a round-robin arbiter and one registered beat per output.
// Input beats carry a destination mask and may be delivered to several outputs over several cycles.
module crossbar_arb #(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 8,
  parameter int DW_DATA = 32,
  localparam int DW_SRC = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [N_IN*DW_DATA-1:0]  in_data,
  input  logic [N_IN*N_OUT-1:0]    in_dst,
  output logic [N_IN-1:0]          in_ready,
  output logic [N_OUT-1:0]         out_valid,
  output logic [N_OUT*DW_DATA-1:0] out_data,
  output logic [N_OUT*DW_SRC-1:0]  out_src,
  input  logic [N_OUT-1:0]         out_ready
);

  // Handshake: a beat moves on a posedge where valid && ready. A source holds
  // data/mask while valid && !ready; an output holds its beat until it transfers.
  logic [DW_DATA-1:0] dat       [N_IN];
  logic [N_OUT-1:0]   dst       [N_IN];
  logic [N_OUT-1:0]   done      [N_IN];
  logic [N_OUT-1:0]   remaining [N_IN];
  logic [N_OUT-1:0]   served    [N_IN];
  logic [N_IN-1:0]    req       [N_OUT];
  logic [DW_SRC-1:0]  ptr       [N_OUT];
  logic [DW_SRC-1:0]  gnt_idx   [N_OUT];
  logic [N_OUT-1:0]   free;
  logic [N_OUT-1:0]   gnt_vld;
  logic [N_OUT-1:0]   out_valid_r;
  logic [DW_DATA-1:0] out_data_r [N_OUT];
  logic [DW_SRC-1:0]  out_src_r  [N_OUT];

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      dat[i]       = in_data[i*DW_DATA +: DW_DATA];
      dst[i]       = in_dst[i*N_OUT +: N_OUT];
      remaining[i] = dst[i] & ~done[i];
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        req[j][i] = in_valid[i] & remaining[i][j];
      end
    end
  end

  // Descending scan: the last hit is the lowest index, either overall (wrap case)
  // or at/after the pointer.
  always_comb begin : arb
    logic              hi_vld;
    logic              lo_vld;
    logic [DW_SRC-1:0] hi_idx;
    logic [DW_SRC-1:0] lo_idx;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = 0; j < N_OUT; j++) begin
      free[j] = !out_valid_r[j] | out_ready[j];
      hi_vld  = 1'b0;
      lo_vld  = 1'b0;
      hi_idx  = '0;
      lo_idx  = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (req[j][i]) begin
          lo_vld = 1'b1;
          lo_idx = DW_SRC'(i);
          if (DW_SRC'(i) >= ptr[j]) begin
            hi_vld = 1'b1;
            hi_idx = DW_SRC'(i);
          end
        end
      end
      gnt_vld[j] = free[j] & lo_vld;
      gnt_idx[j] = hi_vld ? hi_idx : lo_idx;
    end
  end

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      served[i] = '0;
    end
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (gnt_vld[j] && (gnt_idx[j] == DW_SRC'(i))) begin
          served[i][j] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = rst & in_valid[i] & ((remaining[i] & ~served[i]) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_r <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        out_data_r[j] <= '0;
        out_src_r[j]  <= '0;
        ptr[j]        <= '0;
      end
      for (int i = 0; i < N_IN; i++) begin
        done[i] <= '0;
      end
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (gnt_vld[j]) begin
          out_valid_r[j] <= 1'b1;
          out_data_r[j]  <= dat[gnt_idx[j]];
          out_src_r[j]   <= gnt_idx[j];
          ptr[j]         <= (gnt_idx[j] == DW_SRC'(N_IN - 1)) ? '0 : gnt_idx[j] + 1'b1;
        end else if (out_ready[j]) begin
          out_valid_r[j] <= 1'b0;
        end
      end
      // A finished beat clears its history so the next beat starts from its full mask.
      for (int i = 0; i < N_IN; i++) begin
        done[i] <= in_ready[i] ? '0 : (done[i] | served[i]);
      end
    end
  end

  assign out_valid = out_valid_r;

  always_comb begin
    out_data = '0;
    out_src  = '0;
    for (int j = 0; j < N_OUT; j++) begin
      out_data[j*DW_DATA +: DW_DATA] = out_data_r[j];
      out_src[j*DW_SRC +: DW_SRC]    = out_src_r[j];
    end
  end

endmodule

// File: tb/tb_crossbar_arb.sv
// Bench for crossbar_arb (4x4): directed scenarios plus random traffic, checked
// by a per-output expected queue filled from a cycle-level reference model.
module tb_crossbar_arb;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int EW = SW + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NI-1:0]   in_valid = '0;
  logic [NI*DW-1:0] in_data = '0;
  logic [NI*NO-1:0] in_dst = '0;
  logic [NI-1:0]   in_ready;
  logic [NO-1:0]   out_valid;
  logic [NO*DW-1:0] out_data;
  logic [NO*SW-1:0] out_src;
  logic [NO-1:0]   out_ready = '0;

  crossbar_arb #(.N_IN(NI), .N_OUT(NO), .DW_DATA(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_dst(in_dst), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // stimulus state
  logic [NI-1:0] cur_v = '0;
  logic [NI-1:0] consumed = '0;
  logic [DW-1:0] cur_d [NI];
  logic [NO-1:0] cur_m [NI];
  int            n_left [NI];
  logic [NO-1:0] fix_dst [NI];
  bit            rand_dst = 0;
  bit            rand_ordy = 0;
  bit            rand_gap = 0;
  logic [NO-1:0] ordy = '1;
  logic          rst_drv = 1'b0;

  // reference model and scoreboard
  logic [NO-1:0] m_valid = '0;
  int            m_ptr [NO];
  logic [NO-1:0] m_done [NI];
  logic [EW-1:0] exp_q [NO][$];
  int            src_log [NO][$];
  int            cnt_rdy [NI];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic void chk(input string name, input int idx, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t: got 0x%0h, expected 0x%0h", name, idx, $time, act, exp);
    end
  endfunction

  initial begin
    for (int i = 0; i < NI; i++) begin
      n_left[i] = 0; fix_dst[i] = '0; cur_d[i] = '0; cur_m[i] = '0;
      m_done[i] = '0; cnt_rdy[i] = 0;
    end
    for (int j = 0; j < NO; j++) m_ptr[j] = 0;
  end

  // driver: applies inputs just after each posedge, holding a beat until consumed
  initial begin
    forever begin
      @(posedge clk); #1;
      rst = rst_drv;
      out_ready = rand_ordy ? NO'($urandom) : ordy;
      for (int i = 0; i < NI; i++) begin
        if (!cur_v[i] || consumed[i]) begin
          consumed[i] = 1'b0;
          cur_v[i] = 1'b0;
          if (n_left[i] > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            cur_v[i] = 1'b1;
            cur_d[i] = DW'($urandom);
            cur_m[i] = rand_dst ? NO'($urandom) : fix_dst[i];
            n_left[i]--;
          end
        end
        in_valid[i] = cur_v[i];
        in_data[i*DW +: DW] = cur_d[i];
        in_dst[i*NO +: NO] = cur_m[i];
      end
    end
  end

  // reference model: evaluates the coming edge from the stable inputs
  task automatic eval_cycle();
    logic [NO-1:0] rem [NI];
    logic [NO-1:0] srv [NI];
    int gi [NO];
    int c;
    bit exp_rdy;
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        chk("in_ready_in_reset", i, 32'(in_ready[i]), 0);
        m_done[i] = '0;
      end
      for (int j = 0; j < NO; j++) begin
        exp_q[j].delete();
        m_ptr[j] = 0;
      end
      m_valid = '0;
      return;
    end
    for (int i = 0; i < NI; i++) begin
      rem[i] = in_valid[i] ? (in_dst[i*NO +: NO] & ~m_done[i]) : '0;
      srv[i] = '0;
    end
    for (int j = 0; j < NO; j++) begin
      gi[j] = -1;
      if (!m_valid[j] || out_ready[j]) begin
        for (int k = 0; k < NI; k++) begin
          c = (m_ptr[j] + k) % NI;
          if (gi[j] < 0 && rem[c][j]) gi[j] = c;
        end
      end
      if (gi[j] >= 0) srv[gi[j]][j] = 1'b1;
    end
    for (int i = 0; i < NI; i++) begin
      exp_rdy = in_valid[i] && ((rem[i] & ~srv[i]) == '0);
      chk("in_ready", i, 32'(in_ready[i]), 32'(exp_rdy));
      if (in_ready[i]) cnt_rdy[i]++;
      if (exp_rdy) begin
        consumed[i] = 1'b1;
        m_done[i] = '0;
      end else begin
        m_done[i] = m_done[i] | srv[i];
      end
    end
    for (int j = 0; j < NO; j++) begin
      if (gi[j] >= 0) begin
        exp_q[j].push_back({SW'(gi[j]), in_data[gi[j]*DW +: DW]});
        m_valid[j] = 1'b1;
        m_ptr[j] = (gi[j] + 1) % NI;
      end else if (out_ready[j]) begin
        m_valid[j] = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(negedge clk); #1;
    eval_cycle();
  end

  // monitor: compares presented beats with the queue head, pops on transfer
  initial forever begin
    @(negedge clk);
    for (int j = 0; j < NO; j++) begin
      chk("out_valid", j, 32'(out_valid[j]), 32'(exp_q[j].size() != 0));
      if (out_valid[j] && exp_q[j].size() != 0) begin
        chk("out_beat", j, 32'({out_src[j*SW +: SW], out_data[j*DW +: DW]}), 32'(exp_q[j][0]));
        if (out_ready[j]) begin
          void'(exp_q[j].pop_front());
          src_log[j].push_back(int'(out_src[j*SW +: SW]));
        end
      end
    end
  end

  function automatic bit idle();
    bit r = 1;
    for (int i = 0; i < NI; i++)
      if (n_left[i] != 0 || (cur_v[i] && !consumed[i])) r = 0;
    for (int j = 0; j < NO; j++)
      if (exp_q[j].size() != 0) r = 0;
    return r;
  endfunction

  task automatic wait_idle(input int bound);
    int t = 0;
    while (!idle() && t < bound) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", t, 32'(idle()), 1);
  endtask

  task automatic clear_logs();
    for (int j = 0; j < NO; j++) src_log[j].delete();
  endtask

  function automatic int count_src(input int j, input int s);
    int n = 0;
    foreach (src_log[j][k]) if (src_log[j][k] == s) n++;
    return n;
  endfunction

  initial begin
    int exp_seq [6];
    int lim;
    exp_seq = '{0, 1, 3, 0, 1, 3};

    // reset state
    rst_drv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 0, 32'(out_valid), 0);
    chk("rst_out_data_nz", 0, 32'(out_data != '0), 0);
    chk("rst_out_src", 0, 32'(out_src), 0);
    @(posedge clk);
    rst_drv = 1'b1;
    repeat (2) @(posedge clk);

    // unicast: input 2 -> output 0
    clear_logs();
    fix_dst[2] = 4'b0001;
    n_left[2] = 1;
    @(posedge clk);
    cur_d[2] = 16'hA5A5;
    wait_idle(20);
    chk("uni_count", 0, 32'(src_log[0].size()), 1);
    chk("uni_src", 0, (src_log[0].size() > 0) ? 32'(src_log[0][0]) : 32'hFFFF, 2);

    // contention on output 1 from inputs 0,1,3
    clear_logs();
    for (int i = 0; i < NI; i++) cnt_rdy[i] = 0;
    foreach (exp_seq[k]) if (k < 3) begin fix_dst[exp_seq[k]] = 4'b0010; n_left[exp_seq[k]] = 2; end
    wait_idle(40);
    chk("cont_count", 1, 32'(src_log[1].size()), 6);
    for (int k = 0; k < 6; k++)
      chk("cont_src", k, (k < src_log[1].size()) ? 32'(src_log[1][k]) : 32'hFFFF, 32'(exp_seq[k]));
    chk("cont_rdy0", 0, 32'(cnt_rdy[0]), 2);
    chk("cont_rdy1", 1, 32'(cnt_rdy[1]), 2);
    chk("cont_rdy3", 3, 32'(cnt_rdy[3]), 2);

    // multicast with outputs 1 and 3 blocked by stalled beats
    clear_logs();
    ordy = 4'b0101;
    fix_dst[2] = 4'b1010;
    n_left[2] = 1;
    repeat (3) @(posedge clk);
    cnt_rdy[0] = 0;
    fix_dst[0] = 4'b1111;
    n_left[0] = 1;
    repeat (4) @(posedge clk);
    chk("mc_stall_ready", 0, 32'(cnt_rdy[0]), 0);
    ordy = '1;
    wait_idle(20);
    chk("mc_ready_once", 0, 32'(cnt_rdy[0]), 1);
    for (int j = 0; j < NO; j++) chk("mc_once", j, 32'(count_src(j, 0)), 1);

    // hold under stall on output 2 while output 0 keeps flowing
    clear_logs();
    ordy = 4'b1011;
    fix_dst[1] = 4'b0100; n_left[1] = 3;
    fix_dst[3] = 4'b0001; n_left[3] = 6;
    repeat (6) @(posedge clk);
    chk("stall_out2", 2, 32'(src_log[2].size()), 0);
    chk("flow_out0", 0, 32'(src_log[0].size() >= 4), 1);
    ordy = '1;
    wait_idle(40);
    chk("stall_out2_total", 2, 32'(src_log[2].size()), 3);
    chk("flow_out0_total", 0, 32'(src_log[0].size()), 6);

    // zero mask is consumed at once and reaches no output
    clear_logs();
    cnt_rdy[1] = 0;
    fix_dst[1] = '0;
    n_left[1] = 1;
    repeat (4) @(posedge clk);
    chk("zero_ready", 1, 32'(cnt_rdy[1]), 1);
    chk("zero_no_out", 0, 32'(src_log[0].size() + src_log[1].size() + src_log[2].size() + src_log[3].size()), 0);

    // reset in the middle of a multicast
    ordy = 4'b0101;
    fix_dst[2] = 4'b1010; n_left[2] = 1;
    repeat (3) @(posedge clk);
    fix_dst[0] = 4'b1111; n_left[0] = 1;
    repeat (3) @(posedge clk);
    rst_drv = 1'b0;
    @(posedge clk);
    rst_drv = 1'b1;
    clear_logs();
    ordy = '1;
    #2;
    chk("rst_mid_out_valid", 0, 32'(out_valid), 0);
    chk("rst_mid_out_src", 0, 32'(out_src), 0);
    wait_idle(20);
    for (int j = 0; j < NO; j++) begin
      chk("rst_replay_count", j, 32'(src_log[j].size()), 1);
      chk("rst_replay_src", j, (src_log[j].size() > 0) ? 32'(src_log[j][0]) : 32'hFFFF, 0);
    end

    // random traffic: random masks, gaps and backpressure
    rand_dst = 1; rand_ordy = 1; rand_gap = 1;
    for (int i = 0; i < NI; i++) n_left[i] = 60;
    lim = 0;
    while (lim < 3000 && (n_left[0] + n_left[1] + n_left[2] + n_left[3]) != 0) begin
      @(posedge clk);
      lim++;
    end
    rand_ordy = 0; rand_gap = 0; ordy = '1;
    wait_idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, expected completion before t=500000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crossbar_arb.md
# crossbar_arb

Parametrised N_IN-to-N_OUT crossbar with valid/ready handshakes, a per-output round-robin arbiter and one registered beat per output. Each input beat carries a destination bitmask, so one beat can go to any subset of outputs (multicast); the beat is delivered over one or more cycles. Sits between producer lanes and consumer lanes wherever the combinational fixed-index crossbar cannot absorb contention or backpressure.

## Interface
- N_IN, default 8: number of input channels, ≥1.
- N_OUT, default 8: number of output channels, ≥1.
- DW_DATA, default 32: payload width.
- DW_SRC (localparam): $clog2(N_IN), forced to 1 when N_IN==1.
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  N_IN  per-input beat valid.
- in_data  input  N_IN*DW_DATA  payload; input i at [i*DW_DATA +: DW_DATA].
- in_dst  input  N_IN*N_OUT  destination mask; bit [i*N_OUT+j] sends input i to output j.
- in_ready  output  N_IN  beat fully delivered this cycle (combinational).
- out_valid  output  N_OUT  registered beat present.
- out_data  output  N_OUT*DW_DATA  registered payload.
- out_src  output  N_OUT*DW_SRC  index of the input that supplied the beat.
- out_ready  input  N_OUT  consumer accepts the beat.

## Operation
- Source rule: while in_valid[i] && !in_ready[i], the source must hold in_data[i] and in_dst[i] stable.
- Per-input state done[i] (N_OUT bits) records outputs already served for the current beat.
- remaining[i] = in_dst[i] & ~done[i].
- Output j requests: req[i][j] = in_valid[i] & remaining[i][j].
- Output j can load when free[j] = !out_valid[j] | out_ready[j].
- Arbiter j runs only if free[j]. It grants the first requester at or after ptr[j], searching upward modulo N_IN.
- On a grant to input i:
  - out_data[j] <= in_data[i], out_src[j] <= i, out_valid[j] <= 1, ptr[j] <= (i+1) mod N_IN.
- No grant and out_ready[j]: out_valid[j] <= 0; data and src hold.
- No grant and !out_ready[j]: everything holds.
- served[i] = OR over j of the grant to i.
- in_ready[i] = rst & in_valid[i] & ((remaining[i] & ~served[i]) == 0).
- When in_ready[i]: done[i] <= 0.
- Otherwise: done[i] <= done[i] | served[i].
- Multicast: outputs may serve one beat in different cycles. No beat is ever duplicated on the same output.
- in_dst[i]==0 with in_valid[i]: in_ready[i]=1 in the same cycle; the beat is discarded and no output changes.
- Independent outputs grant different inputs in the same cycle; one input may be granted by several outputs at once.
- Reset (rst==0 at posedge):
  - out_valid, out_data, out_src, ptr and done are all cleared to 0.
  - in_ready is forced to 0 while rst==0.
  - A partially delivered multicast is forgotten. After reset the source re-presents the beat to the full mask.

## Timing
- Latency: the beat appears on out_valid/out_data one cycle after the granting edge.
- Throughput: one beat per output per cycle when out_ready is held high.
- Fairness: with K persistent requesters on output j, each requester is granted once in every K grants.
- in_ready depends combinationally on in_valid, in_dst and out_ready. No combinational path exists from in_* to out_*.
- Output handshake: a beat transfers on an edge where out_valid[j] && out_ready[j]. out_valid[j] never drops without such a transfer.

## Test plan
- Unicast, N_IN=N_OUT=4, out_ready=1:
  - Stimulus: input 2 sends 0xA5A5 with mask 4'b0001.
  - Response: in_ready[2] the same cycle; next cycle out_valid[0]=1, out_data[0]=0xA5A5, out_src[0]=2.
- Contention:
  - Stimulus: inputs 0,1,3 hold valid with mask 4'b0010; out_ready=1.
  - Response: out_src[1] sequence is 0,1,3,0,1,3; each input sees in_ready once per 3 cycles.
- Multicast with backpressure:
  - Stimulus: input 0 mask 4'b1111; out_ready=4'b0101, then 4'b1111 after 3 cycles.
  - Response: in_ready[0] stays 0 until outputs 1 and 3 are granted; each output emits the beat exactly once.
- Hold under stall:
  - Stimulus: out_ready[2]=0 for 5 cycles with out_valid[2]=1.
  - Response: out_data[2] and out_src[2] are constant; no new grant on output 2; other outputs keep flowing.
- Zero mask:
  - Stimulus: in_valid[1]=1, mask 0.
  - Response: in_ready[1]=1 immediately; out_valid stays unchanged.
- Reset mid-multicast:
  - Stimulus: drive rst=0 for one cycle after two of four outputs have served the beat.
  - Response: all outputs are 0 and in_ready is 0 during reset; afterwards the re-presented beat reaches all 4 outputs.
